// File: rtl/puf_challenge_sequencer.sv
// Steps one puf_bit instance through N_BITS consecutive challenges and packs the
// per-challenge response bits (LSB first) into resp_word.
module puf_challenge_sequencer #(
  parameter int N_BITS     = 8,
  parameter int CHALL_W    = 8,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1024,
  localparam int IDX_W     = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CHALL_W-1:0] base_chall,
  input  logic               abort,
  input  logic               resp_ack,
  input  logic               puf_resp,
  input  logic               puf_finish,
  output logic [CHALL_W-1:0] puf_chall,
  output logic               puf_rst,
  output logic               puf_en,
  output logic [N_BITS-1:0]  resp_word,
  output logic               resp_valid,
  output logic               busy,
  output logic               timeout_err,
  output logic [IDX_W-1:0]   bit_idx
);

  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    NEXT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CHALL_W-1:0] base_q, base_d;
  logic [N_BITS-1:0]  word_q, word_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      word_q  <= word_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // One counter serves both the CLEAR hold and the RUN timeout.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    word_d  = word_q;
    err_d   = err_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_chall;
          word_d  = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (puf_finish) begin
          word_d[idx_q] = puf_resp;
          state_d       = NEXT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          word_d[idx_q] = 1'b0;
          err_d         = 1'b1;
          state_d       = NEXT;
        end
      end
      NEXT: begin
        cnt_d = '0;
        if (idx_q == IDX_W'(N_BITS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = CLEAR;
        end
      end
      DONE: begin
        if (resp_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // Challenge is derived from registered base/index, so it only moves on the
  // edges that enter CLEAR (start or NEXT).
  assign puf_chall   = base_q + CHALL_W'(idx_q);
  assign puf_en      = (state_q == RUN);
  assign puf_rst     = (state_q != RUN);
  assign busy        = (state_q != IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_word   = word_q;
  assign timeout_err = err_q;
  assign bit_idx     = idx_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench for puf_challenge_sequencer with a behavioural puf_bit model.
module tb_puf_challenge_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, resp_ack, puf_resp, puf_finish;
  logic [7:0] base_chall;
  logic [7:0] puf_chall;
  logic       puf_rst, puf_en, resp_valid, busy, timeout_err;
  logic [7:0] resp_word;
  logic [2:0] bit_idx;

  int tests = 0;
  int errors = 0;

  int d [8];
  logic [7:0] en_cnt;

  logic [7:0] chall_q [$];
  int         len_q   [$];
  logic [8:0] resp_q  [$];

  puf_challenge_sequencer #(
    .N_BITS(8), .CHALL_W(8), .RST_CYCLES(2), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst_n), .start(start), .base_chall(base_chall),
    .abort(abort), .resp_ack(resp_ack), .puf_resp(puf_resp),
    .puf_finish(puf_finish), .puf_chall(puf_chall), .puf_rst(puf_rst),
    .puf_en(puf_en), .resp_word(resp_word), .resp_valid(resp_valid),
    .busy(busy), .timeout_err(timeout_err), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  // PUF model: finish after d[bit] cycles of enable, response = challenge parity.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_cnt <= '0;
    else        en_cnt <= puf_en ? en_cnt + 8'd1 : 8'd0;
  end
  assign puf_finish = puf_en && (int'(en_cnt) == d[bit_idx]);
  assign puf_resp   = ^puf_chall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: challenge per RUN, RUN length, final response, enable/reset exclusivity.
  int   run_len = 0;
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("en_rst_exclusive", {31'd0, puf_en & puf_rst}, 32'd0);
      if (puf_en) begin
        if (run_len == 0) begin
          if (chall_q.size() == 0) check("chall_unexpected", {24'd0, puf_chall}, 32'hFFFF_FFFF);
          else check("puf_chall", {24'd0, puf_chall}, {24'd0, chall_q.pop_front()});
        end
        run_len++;
      end else if (run_len > 0) begin
        if (len_q.size() == 0) check("runlen_unexpected", run_len, 32'hFFFF_FFFF);
        else check("run_len", run_len, len_q.pop_front());
        run_len = 0;
      end
      if (resp_valid && !valid_prev) begin
        if (resp_q.size() == 0) check("resp_unexpected", {23'd0, timeout_err, resp_word}, 32'hFFFF_FFFF);
        else check("resp_word_err", {23'd0, timeout_err, resp_word}, {23'd0, resp_q.pop_front()});
      end
      valid_prev = resp_valid;
    end else begin
      run_len    = 0;
      valid_prev = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_chall"}, {24'd0, puf_chall}, 32'd0);
    check({tag, "_en"}, {31'd0, puf_en}, 32'd0);
    check({tag, "_rst"}, {31'd0, puf_rst}, 32'd1);
    check({tag, "_word"}, {24'd0, resp_word}, 32'd0);
    check({tag, "_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, timeout_err}, 32'd0);
    check({tag, "_idx"}, {29'd0, bit_idx}, 32'd0);
  endtask

  task automatic do_start(input logic [7:0] b);
    @(negedge clk);
    base_chall = b;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic full_run(input logic [7:0] base);
    logic [7:0] c, word;
    logic       err;
    int         len, total, cyc;
    word = '0; err = 1'b0; total = 0;
    for (int i = 0; i < 8; i++) begin
      c = base + 8'(i);
      chall_q.push_back(c);
      if (d[i] < TO) begin
        word[i] = ^c;
        len     = d[i] + 1;
      end else begin
        word[i] = 1'b0;
        err     = 1'b1;
        len     = TO;
      end
      len_q.push_back(len);
      total += 2 + len + 1;
    end
    resp_q.push_back({err, word});
    do_start(base);
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      if (resp_valid) break;
      cyc++;
      start = (cyc == 10);
      if (cyc == 10) base_chall = ~base;
    end
    start = 1'b0;
    check("latency", cyc, total);
    @(negedge clk);
    base_chall = 8'h77;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("done_valid_hold", {31'd0, resp_valid}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd1);
    check("done_word_hold", {24'd0, resp_word}, {24'd0, word});
    check("done_err_hold", {31'd0, timeout_err}, {31'd0, err});
    resp_ack = 1'b1;
    @(posedge clk);
    #1 resp_ack = 1'b0;
    check("ack_valid", {31'd0, resp_valid}, 32'd0);
    check("ack_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("idle_after_ack", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_run_bit(input logic [2:0] b);
    int cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      if (puf_en && bit_idx == b) break;
      cyc++;
    end
    check("wait_run_bit", {31'd0, cyc < 2000}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; resp_ack = 1'b0; base_chall = '0;
    for (int i = 0; i < 8; i++) d[i] = 4;
    #3 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    full_run(8'h3C);
    full_run(8'hFE);

    d[3] = 255;
    full_run(8'h5A);
    d[3] = 4;

    d[6] = TO - 1;
    full_run(8'hA1);
    d[6] = 4;

    for (int i = 0; i < 6; i++) chall_q.push_back(8'h20 + 8'(i));
    for (int i = 0; i < 5; i++) len_q.push_back(5);
    len_q.push_back(1);
    do_start(8'h20);
    wait_run_bit(3'd5);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_en", {31'd0, puf_en}, 32'd0);
    check("abort_rst", {31'd0, puf_rst}, 32'd1);
    check("abort_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    full_run(8'h10);

    d[0] = 255;
    chall_q.push_back(8'h01); chall_q.push_back(8'h02); chall_q.push_back(8'h03);
    len_q.push_back(TO); len_q.push_back(5);
    do_start(8'h01);
    wait_run_bit(3'd2);
    check("pre_rst_word", {24'd0, resp_word}, 32'h02);
    check("pre_rst_err", {31'd0, timeout_err}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d[0] = 4;
    repeat (3) @(negedge clk);

    check("chall_q_empty", chall_q.size(), 32'd0);
    check("len_q_empty", len_q.size(), 32'd0);
    check("resp_q_empty", resp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
